// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the direct-mapped data cache: address/frame layouts and controller states.
// The CNT state only exists when DCACHE_HITCNT_EN is defined.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  localparam int    DC_FRAMES   = 8;
  localparam word_t DC_CNT_ADDR = 32'h0000_3100;

  typedef struct packed {
    logic [25:0] tag;
    logic [2:0]  idx;
    logic        blkoff;
    logic [1:0]  bytoff;
  } dcache_addr_t;

  typedef struct packed {
    logic        valid;
    logic        dirty;
    logic [25:0] tag;
    word_t [1:0] data;
  } dframe_t;

  typedef enum logic [2:0] {
    IDLE, WB0, WB1, LD0, LD1, FLUSH,
`ifdef DCACHE_HITCNT_EN
    CNT,
`endif
    DONE
  } dstate_t;

  function automatic word_t blk_addr(input logic [25:0] tag, input logic [2:0] idx, input logic blk);
    return {tag, idx, blk, 2'b00};
  endfunction
endpackage

// File: rtl/dcache_dm_if.sv
// Datapath/memory signal bundle around the data cache; the slave modport is the cache itself.
interface dcache_dm_if;
  import cpu_types_pkg::*;

  logic  dmemREN, dmemWEN, halt, dhit, flushed;
  word_t dmemaddr, dmemstore, dmemload;
  logic  dREN, dWEN, dwait;
  word_t daddr, dstore, dload;

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    output dmemload, dhit, flushed, dREN, dWEN, daddr, dstore
  );
  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    input  dmemload, dhit, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_frames.sv
// Frame storage for the data cache: one async read port, one write port, sync clear of valid/dirty.
module dcache_frames
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       clr,
  input  logic [2:0] ridx,
  output dframe_t    rframe,
  input  logic       we,
  input  logic [2:0] widx,
  input  dframe_t    wframe
);
  dframe_t frames [DC_FRAMES];

  assign rframe = frames[ridx];

  // Tags and data are left untouched by clear; valid gates them.
  always_ff @(posedge CLK) begin
    if (clr) begin
      for (int i = 0; i < DC_FRAMES; i++) begin
        frames[i].valid <= 1'b0;
        frames[i].dirty <= 1'b0;
      end
    end else if (we) begin
      frames[widx] <= wframe;
    end
  end
endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped write-back/write-allocate data cache, 8 frames x 2 words, with flush on halt.
// DCACHE_HITCNT_EN: keep a signed hit counter and store it to 0x3100 after the flush.
module dcache_dm
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  dcache_dm_if.slave dif
);
  dstate_t      state, state_n;
  dcache_addr_t req_a;
  logic [25:0]  miss_tag;
  logic [2:0]   miss_idx, ridx;
  logic [3:0]   fcnt, fcnt_n;
  dframe_t      rframe, wframe;
  logic         we, req, tag_hit, miss_go, flush_go, flush_req, halt_pend;
  logic         unused_bytoff;

`ifdef DCACHE_HITCNT_EN
  localparam dstate_t FLUSH_EXIT = CNT;
  word_t hit_cnt;
`else
  localparam dstate_t FLUSH_EXIT = DONE;
`endif

  assign req_a         = dcache_addr_t'(dif.dmemaddr);
  assign unused_bytoff = &{1'b0, req_a.bytoff};
  assign req           = dif.dmemREN | dif.dmemWEN;
  assign flush_req     = dif.halt | halt_pend;
  assign tag_hit       = rframe.valid && (rframe.tag == req_a.tag);
  // The miss index is latched so a datapath that changes its address mid-miss cannot redirect the fill.
  assign ridx = (state == FLUSH) ? fcnt[3:1] : (state == IDLE) ? req_a.idx : miss_idx;

  dcache_frames u_frames (
    .CLK    (CLK),
    .clr    (!nRST),
    .ridx   (ridx),
    .rframe (rframe),
    .we     (we),
    .widx   (ridx),
    .wframe (wframe)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      fcnt      <= '0;
      miss_tag  <= '0;
      miss_idx  <= '0;
      halt_pend <= 1'b0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
      if (miss_go) begin
        miss_tag <= req_a.tag;
        miss_idx <= req_a.idx;
      end
      if (dif.halt && (state inside {WB0, WB1, LD0, LD1})) halt_pend <= 1'b1;
    end
  end

`ifdef DCACHE_HITCNT_EN
  // Two's-complement wrap: a run of misses drives the count negative.
  always_ff @(posedge CLK) begin
    if (!nRST)                                 hit_cnt <= '0;
    else if (state == IDLE && !flush_req && req) hit_cnt <= tag_hit ? hit_cnt + 32'd1 : hit_cnt - 32'd1;
  end
`endif

  always_comb begin
    state_n      = state;
    fcnt_n       = fcnt;
    we           = 1'b0;
    wframe       = rframe;
    miss_go      = 1'b0;
    flush_go     = 1'b0;
    dif.dhit     = 1'b0;
    dif.dmemload = '0;
    dif.flushed  = 1'b0;
    dif.dREN     = 1'b0;
    dif.dWEN     = 1'b0;
    dif.daddr    = '0;
    dif.dstore   = '0;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_n = FLUSH;
        end else if (req && tag_hit) begin
          dif.dhit     = 1'b1;
          dif.dmemload = rframe.data[req_a.blkoff];
          if (dif.dmemWEN) begin
            we                         = 1'b1;
            wframe.data[req_a.blkoff] = dif.dmemstore;
            wframe.dirty               = 1'b1;
          end
        end else if (req) begin
          miss_go = 1'b1;
          state_n = (rframe.valid && rframe.dirty) ? WB0 : LD0;
        end
      end
      WB0, WB1: begin
        dif.dWEN   = 1'b1;
        dif.daddr  = blk_addr(rframe.tag, miss_idx, state == WB1);
        dif.dstore = rframe.data[state == WB1];
        if (!dif.dwait) state_n = (state == WB1) ? LD0 : WB1;
      end
      LD0, LD1: begin
        dif.dREN  = 1'b1;
        dif.daddr = blk_addr(miss_tag, miss_idx, state == LD1);
        if (!dif.dwait) begin
          we                      = 1'b1;
          wframe.tag              = miss_tag;
          wframe.dirty            = 1'b0;
          wframe.valid            = (state == LD1);
          wframe.data[state == LD1] = dif.dload;
          state_n                 = (state == LD1) ? IDLE : LD1;
        end
      end
      FLUSH: begin
        flush_go = 1'b1;
        if (rframe.valid && rframe.dirty) begin
          dif.dWEN   = 1'b1;
          dif.daddr  = blk_addr(rframe.tag, fcnt[3:1], fcnt[0]);
          dif.dstore = rframe.data[fcnt[0]];
          flush_go   = !dif.dwait;
        end
        if (flush_go) begin
          fcnt_n = fcnt + 4'd1;
          if (fcnt == 4'hF) state_n = FLUSH_EXIT;
        end
      end
`ifdef DCACHE_HITCNT_EN
      CNT: begin
        dif.dWEN   = 1'b1;
        dif.daddr  = DC_CNT_ADDR;
        dif.dstore = hit_cnt;
        if (!dif.dwait) state_n = DONE;
      end
`endif
      DONE:    dif.flushed = 1'b1;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_dm.sv
// Randomized bench for dcache_dm against an architectural memory model plus per-frame tag/valid/dirty state.
// Honours DCACHE_HITCNT_EN for the extra counter store at the end of a flush.
module tb_dcache_dm;
  import cpu_types_pkg::*;

  typedef struct { bit wr; word_t addr; word_t data; } mtx_t;

  logic clk, nrst;
  dcache_dm_if dif ();

  dcache_dm dut (.CLK(clk), .nRST(nrst), .dif(dif.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  word_t bmem [word_t];
  word_t arch [word_t];
  bit m_v [8];
  bit m_d [8];
  logic [25:0] m_t [8];
  int m_cnt;
  mtx_t log_q [$];
  mtx_t exp_q [$];
  int busy_pct = 0, hold_req = 0, force_busy = 0;
  bit mon_en = 0, pend = 0;
  logic [1:0] p_ctl;
  word_t p_addr, p_data;

  task automatic chk(input string tag, input word_t got, input word_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic word_t init_val(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic word_t bget(input word_t a);
    return bmem.exists(a) ? bmem[a] : init_val(a);
  endfunction

  // Value the datapath must observe: its own writes, otherwise what memory holds.
  function automatic word_t aget(input word_t a);
    return arch.exists(a) ? arch[a] : bget(a);
  endfunction

  function automatic mtx_t mk(input bit wr, input word_t a, input word_t d);
    mtx_t t;
    t.wr = wr; t.addr = a; t.data = d;
    return t;
  endfunction

  // Memory: decides dwait at the falling edge; a transfer completes at the next rising edge if dwait=0.
  initial begin
    dif.dwait = 1'b0;
    dif.dload = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pend) begin
          chk("hold_addr", dif.daddr, p_addr);
          chk("hold_data", dif.dstore, p_data);
          chk("hold_ctl", 32'({dif.dREN, dif.dWEN}), 32'(p_ctl));
        end
        if (dif.dREN || dif.dWEN) chk("ren_wen_excl", 32'(dif.dREN & dif.dWEN), 32'd0);
        if (dif.dWEN && !pend && hold_req > 0) begin
          force_busy = hold_req;
          hold_req   = 0;
        end
        if (force_busy > 0) begin
          dif.dwait  = 1'b1;
          force_busy = force_busy - 1;
        end else begin
          dif.dwait = (int'($urandom_range(0, 99)) < busy_pct);
        end
        dif.dload = dif.dREN ? bget(dif.daddr) : $urandom;
        if (!dif.dwait && dif.dWEN) begin
          bmem[dif.daddr] = dif.dstore;
          log_q.push_back(mk(1'b1, dif.daddr, dif.dstore));
        end
        if (!dif.dwait && dif.dREN) log_q.push_back(mk(1'b0, dif.daddr, '0));
        pend   = (dif.dREN || dif.dWEN) && dif.dwait;
        p_ctl  = {dif.dREN, dif.dWEN};
        p_addr = dif.daddr;
        p_data = dif.dstore;
      end
    end
  end

  task automatic cmp_traffic(input string tag);
    chk({tag, "_ntx"}, word_t'(log_q.size()), word_t'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk({tag, "_wr"}, 32'(log_q[i].wr), 32'(exp_q[i].wr));
      chk({tag, "_addr"}, log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].wr) chk({tag, "_wdata"}, log_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = 1'b0;
    end
    m_cnt = 0;
    arch.delete();
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    dif.dmemREN = 1'b0; dif.dmemWEN = 1'b0; dif.halt = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    model_reset();
  endtask

  // One datapath request held until dhit; exp_cyc>0 also checks the falling edge on which dhit shows.
  task automatic access(input bit wr, input word_t addr, input word_t data, input int exp_cyc);
    logic [25:0] tg;
    logic [2:0]  ix;
    word_t wa, va, exp_rd;
    bit hit, got;
    int n;
    tg = addr[31:6]; ix = addr[5:3]; wa = {addr[31:2], 2'b00};
    hit = m_v[ix] && (m_t[ix] == tg);
    exp_q.delete(); log_q.delete();
    if (!hit) begin
      if (m_v[ix] && m_d[ix])
        for (int b = 0; b < 2; b++) begin
          va = {m_t[ix], ix, 1'(b), 2'b00};
          exp_q.push_back(mk(1'b1, va, aget(va)));
        end
      for (int b = 0; b < 2; b++) exp_q.push_back(mk(1'b0, {tg, ix, 1'(b), 2'b00}, '0));
      m_v[ix] = 1'b1; m_d[ix] = 1'b0; m_t[ix] = tg;
      m_cnt--;
    end
    m_cnt++;
    exp_rd = aget(wa);
    if (wr) begin
      arch[wa] = data;
      m_d[ix]  = 1'b1;
    end
    @(posedge clk); #1;
    dif.dmemWEN   = wr;
    dif.dmemREN   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    dif.dmemaddr  = addr;
    dif.dmemstore = data;
    got = 1'b0; n = 0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("hit_pred", 32'(dif.dhit), 32'(hit));
      got = dif.dhit;
    end
    chk("dhit_seen", 32'(got), 32'd1);
    if (got) begin
      chk("dmemload", dif.dmemload, exp_rd);
      if (exp_cyc > 0) chk("latency", word_t'(n), word_t'(exp_cyc));
    end
    cmp_traffic("acc");
    @(posedge clk); #1;
    dif.dmemREN = 1'b0; dif.dmemWEN = 1'b0;
  endtask

  task automatic do_flush(input bit with_req);
    word_t fa;
    bit done;
    int n;
    exp_q.delete(); log_q.delete();
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 2; b++)
        if (m_v[i] && m_d[i]) begin
          fa = {m_t[i], 3'(i), 1'(b), 2'b00};
          exp_q.push_back(mk(1'b1, fa, aget(fa)));
        end
`ifdef DCACHE_HITCNT_EN
    exp_q.push_back(mk(1'b1, 32'h0000_3100, word_t'(m_cnt)));
`endif
    @(posedge clk); #1;
    dif.halt = 1'b1;
    if (with_req) begin
      dif.dmemREN  = 1'b1;
      dif.dmemaddr = 32'h0000_0FC4;
    end
    done = 1'b0; n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 1 && with_req) chk("halt_prio_dhit", 32'(dif.dhit), 32'd0);
      done = dif.flushed;
    end
    chk("flushed_seen", 32'(done), 32'd1);
    cmp_traffic("flush");
    foreach (arch[k]) chk("mem_after_flush", bget(k), arch[k]);
    @(posedge clk); #1 dif.halt = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("flushed_hold", 32'(dif.flushed), 32'd1);
      chk("done_bus_idle", 32'({dif.dREN, dif.dWEN}), 32'd0);
      chk("done_dhit", 32'(dif.dhit), 32'd0);
    end
    dif.dmemREN = 1'b0;
  endtask

  // Reset while the second fill word is on the bus; the frame must not survive.
  task automatic abort_ld1(input word_t addr);
    bit seen;
    int n;
    @(posedge clk); #1;
    dif.dmemREN = 1'b1; dif.dmemWEN = 1'b0; dif.dmemaddr = addr;
    seen = 1'b0; n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      seen = dif.dREN && (dif.daddr == (addr | 32'h4));
    end
    chk("ld1_reached", 32'(seen), 32'd1);
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1; dif.dmemREN = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_bus_idle", 32'({dif.dREN, dif.dWEN}), 32'd0);
    chk("abort_flushed", 32'(dif.flushed), 32'd0);
    access(1'b0, addr, '0, 4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    word_t a;
    nrst = 1'b0;
    dif.dmemREN = 1'b0; dif.dmemWEN = 1'b0; dif.halt = 1'b0;
    dif.dmemaddr = '0; dif.dmemstore = '0;
    do_reset();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_dhit", 32'(dif.dhit), 32'd0);
    chk("rst_flushed", 32'(dif.flushed), 32'd0);
    chk("rst_dREN", 32'(dif.dREN), 32'd0);
    chk("rst_dWEN", 32'(dif.dWEN), 32'd0);
    chk("rst_daddr", dif.daddr, 32'd0);
    chk("rst_dstore", dif.dstore, 32'd0);
    chk("rst_dmemload", dif.dmemload, 32'd0);

    bmem[32'h40] = 32'hDEAD_BEEF;
    access(1'b0, 32'h0000_0040, '0, 4);
    access(1'b1, 32'h0000_0044, 32'h11, 1);
    access(1'b0, 32'h0000_0044, '0, 1);
    access(1'b1, 32'h0000_0000, 32'hA1, 6);
    access(1'b0, 32'h0000_0200, '0, 6);
    access(1'b1, 32'h0000_0200, 32'h77, 1);
    hold_req = 5;
    access(1'b0, 32'h0000_0000, '0, 11);
    abort_ld1(32'h0000_0088);

    busy_pct = 30;
    repeat (300) begin
      a = {26'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), a, $urandom, 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    do_flush(1'b1);

    do_reset();
    access(1'b1, 32'h0000_0100, 32'hC0FF_EE01, 0);
    access(1'b1, 32'h0000_0104, 32'hC0FF_EE02, 1);
    do_flush(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dcache_dm.md
DCACHE_DM -- requirements
Module: dcache_dm

Interface
REQ-001 SHALL have ports: CLK  in  1  clock; nRST  in  1  synchronous active-low reset, sampled on rising CLK.
REQ-002 SHALL have datapath-side ports: dmemREN in 1 read request; dmemWEN in 1 write request; dmemaddr in 32 byte address; dmemstore in 32 write data; halt in 1 flush request; dmemload out 32 read data; dhit out 1 request serviced; flushed out 1 flush complete.
REQ-003 SHALL have memory-side ports: dREN out 1; dWEN out 1; daddr out 32; dstore out 32; dload in 32; dwait in 1 (high = memory busy).

Function
REQ-004 SHALL be direct-mapped, write-back, write-allocate: 8 frames, each valid, dirty, 26-bit tag and two 32-bit words.
REQ-005 SHALL decompose dmemaddr as tag[31:6], idx[5:3], blkoff[2], bytoff[1:0]; bytoff is ignored.
REQ-006 SHALL assert dhit combinationally in IDLE when (dmemREN|dmemWEN) and the frame is valid with a matching tag; dmemload = addressed word whenever hit, else 0.
REQ-007 On a write hit, the addressed word SHALL take dmemstore and dirty SHALL be set at the next edge.
REQ-008 When REN and WEN are both high, the request SHALL be treated as a write.
REQ-009 SHALL have states IDLE, WB0, WB1, LD0, LD1, FLUSH, CNT, DONE.
REQ-010 On a miss in IDLE: dirty victim -> WB0, else -> LD0.
REQ-011 WB0/WB1 SHALL drive dWEN=1, daddr={victim tag,idx,blk 0/1,2'b00}, dstore=victim word; advance when dwait=0. WB1 -> LD0.
REQ-012 LD0/LD1 SHALL drive dREN=1, daddr={req tag,idx,blk 0/1,2'b00}; on dwait=0 capture dload into the word. LD1 also sets valid=1, dirty=0, tag=req tag -> IDLE, where the request then hits.
REQ-013 Each memory state SHALL hold its outputs stable until dwait=0; dREN and dWEN SHALL never both be high.
REQ-014 Deassertion of dmemREN/dmemWEN mid-miss SHALL NOT abort an in-progress writeback or fill.
REQ-015 halt=1 in IDLE SHALL take priority over any request -> FLUSH; halt arriving mid-miss is honoured on the return to IDLE.
REQ-016 FLUSH SHALL scan a 4-bit counter {idx,blk} from 0 to 15, writing each dirty frame's word to its address (one dWEN per word, advance on dwait=0), and skip clean or invalid entries in one cycle each.
REQ-017 After entry 15, FLUSH SHALL go to CNT when DCACHE_HITCNT_EN is defined, else to DONE.
REQ-018 DONE SHALL assert flushed=1, dhit=0, dREN=dWEN=0, and remain there until reset.
REQ-019 The hit counter (32-bit signed) SHALL increment on each IDLE hit, decrement on each IDLE miss transition, and wrap modulo 2^32.

Reset
REQ-020 With nRST=0 at an edge: state=IDLE, all valid and dirty=0, flush counter=0, hit counter=0.
REQ-021 Reset outputs: dhit=0, flushed=0, dREN=0, dWEN=0, daddr=0, dstore=0, dmemload=0.
REQ-022 Reset during WB, LD or FLUSH SHALL abandon the transaction; memory contents are not restored.

Configuration
REQ-023 Macro DCACHE_HITCNT_EN defined: CNT SHALL drive dWEN=1, daddr=32'h00003100, dstore=hit counter until dwait=0, then go to DONE.
REQ-024 Macro undefined: no CNT state and no counter register; FLUSH goes directly to DONE.

Structure
REQ-025 The dcache address struct (tag/idx/blkoff/bytoff), the frame struct and the state enum SHALL live in the shared cpu_types_pkg; word_t SHALL be used for all 32-bit fields.
REQ-026 Frame storage SHALL be a sub-module, dcache_frames: one read port and one write port, plus synchronous clear of valid and dirty.

Verification
REQ-027 After reset, read 0x40 with memory word 0x40=0xDEADBEEF -> LD0 reads 0x40, LD1 reads 0x44, next IDLE cycle dhit=1 and dmemload=0xDEADBEEF.
REQ-028 Write 0x11 to 0x44, then read 0x44 -> both hit with no memory traffic, and read returns 0x11.
REQ-029 Dirty frame at idx 0 with tag A, then read 0x200 (idx 0) -> WB writes 0x000 and 0x004, then LD reads 0x200 and 0x204, in that order.
REQ-030 dwait held high 5 cycles in WB0 -> daddr and dstore stay stable; state advances only on dwait=0.
REQ-031 Two dirty words, then halt=1 -> exactly two memory writes, plus 0x3100=hit counter if DCACHE_HITCNT_EN is defined; flushed=1 and stays high.
REQ-032 nRST=0 during LD1 -> next cycle IDLE; a re-read of the same address misses.
